// File: rtl/tsmp_pkg.sv
// Shared TSMP dispatcher definitions: ethertype bytes, per-packet decision encoding, parser states.
package tsmp_pkg;

    localparam logic [7:0] TSMP_ETYPE_HI = 8'hFF;
    localparam logic [7:0] TSMP_ETYPE_LO = 8'h01;
    localparam int         CH_IDX_W      = 3;

    // A decision is a channel index unless bypass or drop is set.
    typedef struct packed {
        logic                drop;
        logic                bypass;
        logic [CH_IDX_W-1:0] ch;
    } tsmp_dec_t;

    localparam int        DEC_W      = $bits(tsmp_dec_t);
    localparam tsmp_dec_t DEC_DROP   = '{drop: 1'b1, bypass: 1'b0, ch: 3'd0};
    localparam tsmp_dec_t DEC_BYPASS = '{drop: 1'b0, bypass: 1'b1, ch: 3'd0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } tsmp_state_e;

    function automatic logic is_tsmp(input logic [7:0] hi, input logic [7:0] lo);
        return (hi == TSMP_ETYPE_HI) && (lo == TSMP_ETYPE_LO);
    endfunction

endpackage

// File: rtl/tsmp_dec_fifo.sv
// Synchronous FIFO holding per-packet decisions; first-word fall-through read, async active-low reset.
module tsmp_dec_fifo #(
    parameter int DEPTH = 9,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == CNT_W'(DEPTH));
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rd_data   = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/tsmp_dispatch.sv
// TSMP stream dispatcher: header-window classifier, fixed-latency delay line, per-packet egress steering.
// Build option TSMP_DISPATCH_STAT_EN adds saturating forwarded/dropped packet counters.
module tsmp_dispatch
    import tsmp_pkg::*;
#(
    parameter int DATA_WIDTH = 9,
    parameter int HDR_LEN    = 16,
    parameter int ETYPE_IDX  = 12,
    parameter int TYPE_IDX   = 14,
    parameter int NUM_CH     = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [DATA_WIDTH-1:0]   iv_data,
    input  logic                    i_data_wr,
    input  logic [NUM_CH*8-1:0]     iv_type_cfg,
    input  logic [NUM_CH-1:0]       iv_ch_en,
    output logic [DATA_WIDTH-1:0]   ov_data,
    output logic [NUM_CH-1:0]       ov_data_wr,
    output logic                    o_data_wr_byp,
    output logic [15:0]             ov_fwd_cnt,
    output logic [15:0]             ov_drop_cnt
);
    localparam int IDX_W      = $clog2(HDR_LEN);
    localparam int FIFO_DEPTH = HDR_LEN / 2 + 1;
    localparam int FLAG_BIT   = DATA_WIDTH - 1;

    tsmp_state_e           state_r, state_s;
    logic [IDX_W-1:0]      idx_r, idx_s, cur_idx_s;
    logic [7:0]            etype_hi_r, etype_lo_r, type_r, etype_lo_eff_s, type_eff_s;
    logic                  accept_s, push_s, in_flag_s;
    tsmp_dec_t             match_dec_s, class_dec_s, push_dec_s;
    logic [DEC_W-1:0]      fifo_rd_s;
    logic                  fifo_empty_s, fifo_full_s, fifo_push_s, pop_s;
    logic [DATA_WIDTH-1:0] in_word_r;
    logic                  in_vld_r;
    logic [DATA_WIDTH-1:0] dl_word_r [HDR_LEN];
    logic [HDR_LEN-1:0]    dl_vld_r;
    logic [DATA_WIDTH-1:0] exit_word_s, data_s;
    logic                  exit_vld_s, exit_flag_s, out_open_r, out_open_s, emit_s, byp_s;
    logic [NUM_CH-1:0]     wr_s;
    tsmp_dec_t             cur_dec_r, dec_s;

    assign in_flag_s   = iv_data[FLAG_BIT];
    assign cur_idx_s   = (state_r == ST_IDLE) ? {IDX_W{1'b0}} : idx_r;
    assign exit_word_s = dl_word_r[HDR_LEN-1];
    assign exit_vld_s  = dl_vld_r[HDR_LEN-1];
    assign exit_flag_s = exit_word_s[FLAG_BIT];

    // Classification; a byte at the last header index is taken straight off the input bus.
    always_comb begin
        etype_lo_eff_s = etype_lo_r;
        type_eff_s     = type_r;
        match_dec_s    = DEC_DROP;
        if (ETYPE_IDX + 1 == HDR_LEN - 1) etype_lo_eff_s = iv_data[7:0];
        else                              etype_lo_eff_s = etype_lo_r;
        if (TYPE_IDX == HDR_LEN - 1) type_eff_s = iv_data[7:0];
        else                         type_eff_s = type_r;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (iv_ch_en[c] && (iv_type_cfg[8*c +: 8] == type_eff_s)) begin
                match_dec_s = '{drop: 1'b0, bypass: 1'b0, ch: CH_IDX_W'(c)};
            end else begin
                match_dec_s = match_dec_s;
            end
        end
        if (is_tsmp(etype_hi_r, etype_lo_eff_s)) class_dec_s = match_dec_s;
        else                                     class_dec_s = DEC_BYPASS;
    end

    // Parser next state, word acceptance and decision push.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        accept_s   = 1'b0;
        push_s     = 1'b0;
        push_dec_s = DEC_DROP;
        case (state_r)
            ST_IDLE: begin
                if (i_data_wr && in_flag_s) begin
                    accept_s = 1'b1;
                    state_s  = ST_HDR;
                    idx_s    = IDX_W'(1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!i_data_wr) begin
                    push_s  = 1'b1;
                    state_s = ST_BODY;
                end else if (in_flag_s) begin
                    accept_s = 1'b1;
                    push_s   = 1'b1;
                    state_s  = ST_IDLE;
                end else if (idx_r == IDX_W'(HDR_LEN - 1)) begin
                    accept_s   = 1'b1;
                    push_s     = 1'b1;
                    push_dec_s = class_dec_s;
                    state_s    = ST_BODY;
                end else begin
                    accept_s = 1'b1;
                    idx_s    = idx_r + IDX_W'(1);
                end
            end
            ST_BODY: begin
                if (i_data_wr && in_flag_s) begin
                    accept_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    accept_s = i_data_wr;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Parser state, header index and captured header bytes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IDX_W{1'b0}};
            etype_hi_r <= 8'h00;
            etype_lo_r <= 8'h00;
            type_r     <= 8'h00;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            if (accept_s && (state_r != ST_BODY) && (cur_idx_s == IDX_W'(ETYPE_IDX)))
                etype_hi_r <= iv_data[7:0];
            if (accept_s && (state_r != ST_BODY) && (cur_idx_s == IDX_W'(ETYPE_IDX + 1)))
                etype_lo_r <= iv_data[7:0];
            if (accept_s && (state_r != ST_BODY) && (cur_idx_s == IDX_W'(TYPE_IDX)))
                type_r <= iv_data[7:0];
        end
    end

    assign fifo_push_s = push_s & ~fifo_full_s;

    tsmp_dec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DEC_W)
    ) u_dec_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (fifo_push_s),
        .wr_data (push_dec_s),
        .pop     (pop_s),
        .rd_data (fifo_rd_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s)
    );

    // Ingress register plus HDR_LEN-stage delay line; rejected words travel as empty slots.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_word_r <= {DATA_WIDTH{1'b0}};
            in_vld_r  <= 1'b0;
            for (int i = 0; i < HDR_LEN; i++) begin
                dl_word_r[i] <= {DATA_WIDTH{1'b0}};
            end
            dl_vld_r <= {HDR_LEN{1'b0}};
        end else begin
            in_word_r    <= accept_s ? iv_data : {DATA_WIDTH{1'b0}};
            in_vld_r     <= accept_s;
            dl_word_r[0] <= in_word_r;
            for (int i = 1; i < HDR_LEN; i++) begin
                dl_word_r[i] <= dl_word_r[i-1];
            end
            dl_vld_r <= {dl_vld_r[HDR_LEN-2:0], in_vld_r};
        end
    end

    // Egress steering: a head leaving the line pops its decision, held until the tail leaves.
    always_comb begin
        pop_s      = 1'b0;
        dec_s      = cur_dec_r;
        out_open_s = out_open_r;
        data_s     = {DATA_WIDTH{1'b0}};
        wr_s       = {NUM_CH{1'b0}};
        byp_s      = 1'b0;
        if (exit_vld_s && exit_flag_s && !out_open_r) begin
            pop_s      = 1'b1;
            out_open_s = 1'b1;
            if (fifo_empty_s) dec_s = DEC_DROP;
            else              dec_s = tsmp_dec_t'(fifo_rd_s);
        end else if (exit_vld_s && exit_flag_s) begin
            out_open_s = 1'b0;
        end else begin
            out_open_s = out_open_r;
        end
        emit_s = exit_vld_s && (pop_s || out_open_r) && !dec_s.drop;
        if (emit_s) begin
            data_s = exit_word_s;
            if (dec_s.bypass) begin
                byp_s = 1'b1;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (dec_s.ch == CH_IDX_W'(c)) wr_s[c] = 1'b1;
                    else                          wr_s[c] = 1'b0;
                end
            end
        end else begin
            data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Registered egress word, strobes and per-packet decision hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_open_r    <= 1'b0;
            cur_dec_r     <= DEC_DROP;
            ov_data       <= {DATA_WIDTH{1'b0}};
            ov_data_wr    <= {NUM_CH{1'b0}};
            o_data_wr_byp <= 1'b0;
        end else begin
            out_open_r    <= out_open_s;
            cur_dec_r     <= dec_s;
            ov_data       <= data_s;
            ov_data_wr    <= wr_s;
            o_data_wr_byp <= byp_s;
        end
    end

`ifdef TSMP_DISPATCH_STAT_EN
    logic [15:0] fwd_cnt_r;
    logic [15:0] drop_cnt_r;

    // Saturating packet counters, one step per pushed decision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fwd_cnt_r  <= 16'h0000;
            drop_cnt_r <= 16'h0000;
        end else if (push_s) begin
            if (push_dec_s.drop) begin
                if (drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'h0001;
            end else begin
                if (fwd_cnt_r != 16'hFFFF) fwd_cnt_r <= fwd_cnt_r + 16'h0001;
            end
        end
    end

    assign ov_fwd_cnt  = fwd_cnt_r;
    assign ov_drop_cnt = drop_cnt_r;
`else
    assign ov_fwd_cnt  = 16'h0000;
    assign ov_drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tsmp_dispatch.sv
// Directed bench for tsmp_dispatch: per-word expectations queued at send time, compared as words egress.
module tb_tsmp_dispatch;
    localparam int HL  = 16;
    localparam int LAT = HL + 2;
`ifdef TSMP_DISPATCH_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    typedef struct {
        int unsigned cyc;
        logic [8:0]  data;
        logic [3:0]  wr;
        logic        byp;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [8:0]  iv_data   = 9'h000;
    logic        i_data_wr = 1'b0;
    logic [31:0] type_cfg  = 32'h2216_0100;
    logic [3:0]  ch_en     = 4'hF;
    logic [8:0]  ov_data;
    logic [3:0]  ov_data_wr;
    logic        o_data_wr_byp;
    logic [15:0] fwd_cnt;
    logic [15:0] drop_cnt;

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int exp_fwd = 0;
    int exp_drop = 0;
    exp_t sb[$];

    tsmp_dispatch dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .iv_data       (iv_data),
        .i_data_wr     (i_data_wr),
        .iv_type_cfg   (type_cfg),
        .iv_ch_en      (ch_en),
        .ov_data       (ov_data),
        .ov_data_wr    (ov_data_wr),
        .o_data_wr_byp (o_data_wr_byp),
        .ov_fwd_cnt    (fwd_cnt),
        .ov_drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Egress monitor: one comparison per cycle against the scoreboard head or an idle bus.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $error("FAIL egress_missing: word %0h due at cycle %0d not seen (now %0d)", sb[0].data, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            check("egress", {18'h0, ov_data, ov_data_wr, o_data_wr_byp}, {18'h0, sb[0].data, sb[0].wr, sb[0].byp});
            void'(sb.pop_front());
        end else begin
            check("idle", {18'h0, ov_data, ov_data_wr, o_data_wr_byp}, 32'h0);
        end
    end

    // Reference routing: -1 bypass, -2 drop, otherwise the channel index.
    function automatic int route(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] typ);
        if (!(hi == 8'hFF && lo == 8'h01)) return -1;
        for (int c = 0; c < 4; c++) begin
            if (ch_en[c] && type_cfg[8*c +: 8] == typ) return c;
        end
        return -2;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            iv_data   = 9'h000;
            i_data_wr = 1'b0;
        end
    endtask

    task automatic check_cnt();
        check("fwd_cnt", {16'h0, fwd_cnt}, STAT ? exp_fwd : 0);
        check("drop_cnt", {16'h0, drop_cnt}, STAT ? exp_drop : 0);
    endtask

    task automatic send_pkt(input int len, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] typ, input int gap_at, input logic [7:0] seed);
        int r;
        logic [8:0] w;
        logic [3:0] wr_e;
        if (len <= HL || (gap_at >= 0 && gap_at < HL)) r = -2;
        else r = route(hi, lo, typ);
        if (r == -2) exp_drop++;
        else exp_fwd++;
        wr_e = (r >= 0) ? 4'(1 << r) : 4'b0000;
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) begin
                @(negedge clk);
                iv_data   = 9'h000;
                i_data_wr = 1'b0;
            end
            w[7:0] = (i == 12) ? hi : (i == 13) ? lo : (i == 14) ? typ : 8'(seed + 8'(i * 7));
            w[8]   = (i == 0) || (i == len - 1);
            @(negedge clk);
            iv_data   = w;
            i_data_wr = 1'b1;
            if (r != -2) sb.push_back('{cyc + LAT, w, wr_e, (r == -1)});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_outputs", {18'h0, ov_data, ov_data_wr, o_data_wr_byp}, 32'h0);
        check_cnt();
        rst_n = 1'b1;
        idle(2);

        send_pkt(20, 8'hFF, 8'h01, 8'h16, -1, 8'h10);
        idle(LAT + 4);
        check_cnt();

        send_pkt(20, 8'hFF, 8'h01, 8'h7E, -1, 8'h20);
        idle(LAT + 4);
        check_cnt();

        ch_en = 4'b1011;
        send_pkt(20, 8'hFF, 8'h01, 8'h16, -1, 8'h30);
        idle(LAT + 4);
        ch_en = 4'hF;
        check_cnt();

        send_pkt(20, 8'h08, 8'h00, 8'h00, -1, 8'h40);
        send_pkt(20, 8'hFF, 8'h01, 8'h00, -1, 8'h50);
        idle(LAT + 4);
        check_cnt();

        repeat (3) send_pkt(2, 8'h00, 8'h00, 8'h00, -1, 8'h60);
        idle(LAT + 4);
        check_cnt();

        send_pkt(20, 8'hFF, 8'h01, 8'h16, 5, 8'h70);
        send_pkt(24, 8'hFF, 8'h01, 8'h22, -1, 8'h80);
        idle(LAT + 4);
        check_cnt();

        send_pkt(21, 8'hFF, 8'h01, 8'h01, 18, 8'h90);
        idle(LAT + 4);

        type_cfg = 32'h2216_1600;
        send_pkt(20, 8'hFF, 8'h01, 8'h16, -1, 8'hA0);
        idle(LAT + 4);
        type_cfg = 32'h2216_0100;

        @(negedge clk);
        iv_data   = 9'h055;
        i_data_wr = 1'b1;
        idle(LAT + 2);
        check_cnt();

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            iv_data   = {(i == 0), 8'(8'hB0 + i)};
            i_data_wr = 1'b1;
        end
        @(negedge clk);
        iv_data   = 9'h000;
        i_data_wr = 1'b0;
        rst_n     = 1'b0;
        exp_fwd   = 0;
        exp_drop  = 0;
        idle(3);
        check("rst_mid_outputs", {18'h0, ov_data, ov_data_wr, o_data_wr_byp}, 32'h0);
        check_cnt();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_pkt(20, 8'hFF, 8'h01, 8'h22, -1, 8'hC0);
        idle(LAT + 4);
        check_cnt();

        for (int t = 0; t < 200 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL drain: %0d expected words never emitted", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
